// File: rtl/painterengine_gpu_reader_pkg.sv
// Shared definitions for the multi-channel GPU DMA reader.
// Holds the FSM state encoding, the error codes reported on
// o_wire_error_type, the fixed AXI AR field values and the per-transfer
// request record latched at grant time.
package painterengine_gpu_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PARAM_CHECK,
    S_CALC,
    S_ADDR,
    S_DATA,
    S_DONE,
    S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    ERR_OK    = 3'b000,
    ERR_PARAM = 3'b010,
    ERR_AR_TO = 3'b011,
    ERR_R_TO  = 3'b100,
    ERR_PROTO = 3'b101,
    ERR_RESP  = 3'b110
  } err_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_MOD  = 4'b0010;

  // Byte address and beat count of the transfer being served.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] len;
  } xfer_t;

  // log2 of the beat size in bytes (ARSIZE and the alignment mask).
  function automatic int log2_bytes(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/painterengine_gpu_dma_reader_nch_if.sv
// AXI read-address / read-data bus between the reader and the memory slave.
// master: the DMA reader (drives AR, RREADY); slave: the memory side.
interface painterengine_gpu_dma_reader_nch_if #(
  parameter int DATA_WIDTH = 32
);
  logic [3:0]            arid;
  logic [31:0]           araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;
  logic                  arvalid;
  logic                  arready;
  logic [3:0]            rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/painterengine_gpu_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request after the
// last-granted index and presents it as one-hot grant plus binary index.
// Ports: clk/rst, req (CHANNELS), advance (commit the current pick as the
// new last-granted index), gnt (one-hot), idx, any (some request present).
// Reset points at CHANNELS-1 so channel 0 wins first.
module painterengine_gpu_rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int IW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic [CHANNELS-1:0] gnt,
  output logic [IW-1:0]       idx,
  output logic                any
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;

  // Scan from farthest to nearest so the nearest candidate after ptr
  // is the last (winning) assignment.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      cand = IW'((int'(ptr) + i) % CHANNELS);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
    gnt[idx] = any;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr <= IW'(CHANNELS - 1);
    else if (advance) ptr <= idx;
  end
endmodule

// File: rtl/painterengine_gpu_dma_reader_nch.sv
// Multi-channel AXI DMA reader. Clients raise a level request with a byte
// address and beat length; a round-robin arbiter picks one, the FSM splits
// the transfer into INCR bursts (<= MAX_BURST, never crossing 4 KB) and
// routes returned beats to the granted client slice.
// Ports: i_wire_clock/i_wire_reset (async, active high), per-channel
// request/address/length/data_next in, grant/done/data/data_valid out,
// busy/error/error_type status, error_clear, axi (master modport).
// Optional watchdog: define PAINTERENGINE_GPU_READER_TIMEOUT_EN.
module painterengine_gpu_dma_reader_nch
  import painterengine_gpu_reader_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_BURST    = 256,
  parameter int TIMEOUT_BITS = 19
) (
  input  logic                           i_wire_clock,
  input  logic                           i_wire_reset,
  input  logic [CHANNELS-1:0]            i_wire_request,
  input  logic [CHANNELS*32-1:0]         i_wire_address,
  input  logic [CHANNELS*32-1:0]         i_wire_length,
  output logic [CHANNELS-1:0]            o_wire_grant,
  output logic [CHANNELS-1:0]            o_wire_done,
  output logic [CHANNELS*DATA_WIDTH-1:0] o_wire_data,
  output logic [CHANNELS-1:0]            o_wire_data_valid,
  input  logic [CHANNELS-1:0]            i_wire_data_next,
  output logic                           o_wire_busy,
  output logic                           o_wire_error,
  output logic [2:0]                     o_wire_error_type,
  input  logic                           i_wire_error_clear,
  painterengine_gpu_dma_reader_nch_if.master axi
);
  localparam int IW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LOG2B = log2_bytes(DATA_WIDTH);

  state_t                state;
  err_t                  err;
  xfer_t                 xfer;
  logic [IW-1:0]         chan;
  logic [31:0]           offset;
  logic [8:0]            burst, beat_cnt;
  logic [31:0]           araddr_r;
  logic [7:0]            arlen_r;
  logic                  arvalid_r;
  logic [CHANNELS-1:0]   grant_r, done_r;
  logic [CHANNELS-1:0]   arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;
  logic [31:0]           cur_addr, remain, bound_beats, calc_len, next_off;
  logic                  beat, last_beat, wd_expired, unused_sig;

  painterengine_gpu_rr_arbiter #(.CHANNELS(CHANNELS), .IW(IW)) u_arb (
    .clk     (i_wire_clock),
    .rst     (i_wire_reset),
    .req     (i_wire_request),
    .advance (state == S_IDLE && arb_any),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .any     (arb_any)
  );

  // Next burst size: limited by what is left, MAX_BURST and the 4 KB page.
  always_comb begin
    cur_addr    = xfer.addr + (offset << LOG2B);
    remain      = xfer.len - offset;
    bound_beats = (32'h1000 - {20'd0, cur_addr[11:0]}) >> LOG2B;
    calc_len    = remain;
    if (calc_len > 32'(MAX_BURST)) calc_len = 32'(MAX_BURST);
    if (calc_len > bound_beats)    calc_len = bound_beats;
  end

  assign beat      = axi.rvalid && axi.rready;
  assign last_beat = (beat_cnt == burst - 9'd1);
  assign next_off  = offset + 32'(burst);

`ifdef PAINTERENGINE_GPU_READER_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] wd;
  // Counts consecutive stalled cycles in ADDR/DATA; any handshake restarts it.
  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset)                                   wd <= '0;
    else if ((state == S_ADDR && !axi.arready) ||
             (state == S_DATA && !beat))                wd <= wd + 1'b1;
    else                                                wd <= '0;
  end
  assign wd_expired = wd[TIMEOUT_BITS-1];
  assign unused_sig = ^axi.rid;
`else
  assign wd_expired = 1'b0;
  assign unused_sig = ^axi.rid ^ (TIMEOUT_BITS == 0);
`endif

  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      state     <= S_IDLE;
      err       <= ERR_OK;
      xfer      <= '0;
      chan      <= '0;
      offset    <= '0;
      burst     <= '0;
      beat_cnt  <= '0;
      araddr_r  <= '0;
      arlen_r   <= '0;
      arvalid_r <= 1'b0;
      grant_r   <= '0;
      done_r    <= '0;
    end else begin
      done_r <= '0;
      case (state)
        S_IDLE: if (arb_any) begin
          chan      <= arb_idx;
          xfer.addr <= i_wire_address[int'(arb_idx)*32 +: 32];
          xfer.len  <= i_wire_length[int'(arb_idx)*32 +: 32];
          grant_r   <= arb_gnt;
          state     <= S_PARAM_CHECK;
        end
        S_PARAM_CHECK: begin
          if ((xfer.addr & 32'(BYTES - 1)) != 32'd0 || xfer.len == 32'd0) begin
            err   <= ERR_PARAM;
            state <= S_ERROR;
          end else begin
            offset <= '0;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          araddr_r  <= cur_addr;
          arlen_r   <= 8'(calc_len - 32'd1);
          burst     <= 9'(calc_len);
          beat_cnt  <= '0;
          arvalid_r <= 1'b1;
          state     <= S_ADDR;
        end
        S_ADDR: begin
          if (wd_expired) begin
            err       <= ERR_AR_TO;
            arvalid_r <= 1'b0;
            state     <= S_ERROR;
          end else if (axi.arready) begin
            arvalid_r <= 1'b0;
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (wd_expired) begin
            err   <= ERR_R_TO;
            state <= S_ERROR;
          end else if (beat) begin
            // Bad response wins over a framing error on the same beat.
            if (axi.rresp != 2'b00) begin
              err   <= ERR_RESP;
              state <= S_ERROR;
            end else if (axi.rlast != last_beat) begin
              err   <= ERR_PROTO;
              state <= S_ERROR;
            end else if (last_beat) begin
              offset <= next_off;
              if (next_off == xfer.len) begin
                done_r[chan] <= 1'b1;
                state        <= S_DONE;
              end else begin
                state <= S_CALC;
              end
            end else begin
              beat_cnt <= beat_cnt + 9'd1;
            end
          end
        end
        S_DONE: begin
          grant_r <= '0;
          state   <= S_IDLE;
        end
        S_ERROR: if (i_wire_error_clear) begin
          err     <= ERR_OK;
          grant_r <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Beat routing uses the latched channel index, not the live requests.
  always_comb begin
    o_wire_data       = '0;
    o_wire_data_valid = '0;
    axi.rready        = 1'b0;
    if (state == S_DATA) begin
      o_wire_data[int'(chan)*DATA_WIDTH +: DATA_WIDTH] = axi.rdata;
      o_wire_data_valid[chan]                          = axi.rvalid;
      axi.rready                                       = i_wire_data_next[chan];
    end
  end

  assign axi.arid    = '0;
  assign axi.araddr  = araddr_r;
  assign axi.arlen   = arlen_r;
  assign axi.arsize  = 3'(LOG2B);
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arlock  = 1'b0;
  assign axi.arcache = AXI_CACHE_MOD;
  assign axi.arprot  = '0;
  assign axi.arqos   = '0;
  assign axi.arvalid = arvalid_r;

  assign o_wire_grant      = grant_r;
  assign o_wire_done       = done_r;
  assign o_wire_busy       = (state != S_IDLE);
  assign o_wire_error      = (state == S_ERROR);
  assign o_wire_error_type = err;
endmodule

// File: tb/tb_painterengine_gpu_dma_reader_nch.sv
// Scoreboard bench for painterengine_gpu_dma_reader_nch: the stimulus
// process pushes expected AR commands, data beats and done pulses; a
// monitor pops and compares them as the DUT presents them; a small AXI
// slave model answers AR requests with beats whose data is the beat address.
module tb_painterengine_gpu_dma_reader_nch;
  localparam int CH = 4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     req, data_next, grant, done, dvalid;
  logic [CH*32-1:0]  addr, len;
  logic [CH*DW-1:0]  data;
  logic              busy, error, clr;
  logic [2:0]        etype;

  painterengine_gpu_dma_reader_nch_if #(.DATA_WIDTH(DW)) axi();

  painterengine_gpu_dma_reader_nch #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .MAX_BURST(256), .TIMEOUT_BITS(19)
  ) dut (
    .i_wire_clock       (clk),
    .i_wire_reset       (rst),
    .i_wire_request     (req),
    .i_wire_address     (addr),
    .i_wire_length      (len),
    .o_wire_grant       (grant),
    .o_wire_done        (done),
    .o_wire_data        (data),
    .o_wire_data_valid  (dvalid),
    .i_wire_data_next   (data_next),
    .o_wire_busy        (busy),
    .o_wire_error       (error),
    .o_wire_error_type  (etype),
    .i_wire_error_clear (clr),
    .axi                (axi)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { int ch; logic [31:0] data; } beat_t;

  ar_t           exp_ar[$];
  beat_t         exp_beat[$];
  logic [CH-1:0] exp_done[$];
  ar_t           slv_q[$];
  int            checks = 0;
  int            errors = 0;
  int            inj_rlast = -1;
  int            inj_resp  = -1;
  bit            slv_flush = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
    exp_ar.push_back('{addr: a, len: l});
  endtask

  task automatic push_beats(input int ch, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) exp_beat.push_back('{ch: ch, data: base + 32'(k * 4)});
  endtask

  task automatic request(input int ch, input logic [31:0] a, input logic [31:0] l);
    addr[ch*32 +: 32] = a;
    len[ch*32 +: 32]  = l;
    req[ch]           = 1'b1;
  endtask

  task automatic wait_grant_drop(input int ch);
    int n = 0;
    while (!grant[ch] && n < 200) begin @(negedge clk); n++; end
    chk($sformatf("grant_ch%0d", ch), 128'(grant), 128'(4'(1) << ch));
    req[ch] = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input bit stall);
    int n = 0;
    while ((exp_ar.size() + exp_beat.size() + exp_done.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
      data_next = stall ? CH'($urandom) : '1;
    end
    data_next = '1;
    chk("drain_in_budget", 128'(n < budget), 128'(1));
  endtask

  task automatic wait_error(input logic [2:0] code, input logic [CH-1:0] g);
    int n = 0;
    while (!error && n < 200) begin @(negedge clk); n++; end
    chk("error_type", 128'(etype), 128'(code));
    chk("error_grant_held", 128'({error, grant}), 128'({1'b1, g}));
  endtask

  task automatic clear_err();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("after_clear", 128'({busy, error, etype, grant}), 128'(0));
  endtask

  // AXI slave model: AR accepted immediately, beats streamed back to back.
  initial begin : slave
    bit r_f;
    int beat;
    r_f = 1'b0; beat = 0;
    axi.arready = 1'b1; axi.rvalid = 1'b0; axi.rid = '0;
    axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || slv_flush) begin
        slv_q.delete(); beat = 0; r_f = 1'b0; slv_flush = 1'b0;
        axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = '0;
      end else begin
        if (r_f) begin
          beat++;
          if (beat > int'(slv_q[0].len)) begin slv_q.delete(0); beat = 0; end
        end
        if (slv_q.size() != 0) begin
          axi.rvalid = 1'b1;
          axi.rdata  = slv_q[0].addr + 32'(beat * 4);
          axi.rlast  = (beat == int'(slv_q[0].len)) || (beat == inj_rlast);
          axi.rresp  = (beat == inj_resp) ? 2'd2 : 2'd0;
        end else begin
          axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = '0;
        end
        #1;
        if (axi.arvalid && axi.arready) slv_q.push_back('{addr: axi.araddr, len: axi.arlen});
        r_f = axi.rvalid && axi.rready;
      end
    end
  end

  initial begin : monitor
    ar_t           ea;
    beat_t         eb;
    logic [CH-1:0] ed;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        if (axi.arvalid && axi.arready) begin
          chk("ar_expected", 128'(exp_ar.size() != 0), 128'(1));
          if (exp_ar.size() != 0) begin
            ea = exp_ar.pop_front();
            chk("araddr", 128'(axi.araddr), 128'(ea.addr));
            chk("arlen", 128'(axi.arlen), 128'(ea.len));
          end
          chk("ar_fixed", 128'({axi.arid, axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot, axi.arqos}),
              128'({4'd0, 3'd2, 2'd1, 1'b0, 4'b0010, 3'd0, 4'd0}));
        end
        for (int c = 0; c < CH; c++) begin
          if (dvalid[c] && data_next[c]) begin
            chk("beat_expected", 128'(exp_beat.size() != 0), 128'(1));
            if (exp_beat.size() != 0) begin
              eb = exp_beat.pop_front();
              chk("beat_ch", 128'(c), 128'(eb.ch));
              chk("beat_data", 128'(data), 128'(eb.data) << (eb.ch * 32));
            end
          end
        end
        if (done != '0) begin
          chk("done_expected", 128'(exp_done.size() != 0), 128'(1));
          if (exp_done.size() != 0) begin
            ed = exp_done.pop_front();
            chk("done", 128'(done), 128'(ed));
          end
        end
      end
    end
  end

  initial begin : global_timeout
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1; req = '0; data_next = '1; clr = 1'b0; addr = '0; len = '0;
    repeat (3) @(negedge clk);
    chk("reset_status", 128'({busy, error, etype}), 128'(0));
    chk("reset_grant_done", 128'({grant, done}), 128'(0));
    chk("reset_axi", 128'({axi.arvalid, axi.rready, dvalid}), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Single 8-beat burst on channel 2.
    push_ar(32'h1000, 8'd7); push_beats(2, 32'h1000, 8); exp_done.push_back(4'b0100);
    request(2, 32'h1000, 32'd8);
    wait_grant_drop(2);
    wait_drain(300, 1'b0);

    // 600 beats from 0x0FF0: split at the 4 KB boundary and at MAX_BURST,
    // consumer ready toggling randomly.
    push_ar(32'h0FF0, 8'd3); push_ar(32'h1000, 8'd255);
    push_ar(32'h1400, 8'd255); push_ar(32'h1800, 8'd83);
    push_beats(0, 32'h0FF0, 600); exp_done.push_back(4'b0001);
    request(0, 32'h0FF0, 32'd600);
    wait_grant_drop(0);
    wait_drain(5000, 1'b1);

    // ch1 and ch3 together: ch1, ch3, ch1.
    push_ar(32'h2000, 8'd1); push_beats(1, 32'h2000, 2); exp_done.push_back(4'b0010);
    push_ar(32'h3000, 8'd2); push_beats(3, 32'h3000, 3); exp_done.push_back(4'b1000);
    push_ar(32'h2000, 8'd1); push_beats(1, 32'h2000, 2); exp_done.push_back(4'b0010);
    request(1, 32'h2000, 32'd2);
    request(3, 32'h3000, 32'd3);
    begin
      int nd = 0;
      int n  = 0;
      while (nd < 3 && n < 500) begin
        @(negedge clk); n++;
        if (done != '0) nd++;
      end
      req = '0;
      chk("rr_three_done", 128'(nd), 128'(3));
    end
    wait_drain(200, 1'b0);

    // Misaligned address: parameter error, no AR issued.
    request(0, 32'h1002, 32'd4);
    wait_grant_drop(0);
    wait_error(3'b010, 4'b0001);
    clear_err();

    // Early RLAST on the third beat of a 4-beat burst.
    inj_rlast = 2;
    push_ar(32'h4000, 8'd3); push_beats(1, 32'h4000, 3);
    request(1, 32'h4000, 32'd4);
    wait_grant_drop(1);
    wait_error(3'b101, 4'b0010);
    inj_rlast = -1; slv_flush = 1'b1;
    clear_err();

    // Slave error response on the first beat.
    inj_resp = 0;
    push_ar(32'h5000, 8'd3); push_beats(2, 32'h5000, 1);
    request(2, 32'h5000, 32'd4);
    wait_grant_drop(2);
    wait_error(3'b110, 4'b0100);
    inj_resp = -1; slv_flush = 1'b1;
    clear_err();
    chk("queues_empty", 128'(exp_ar.size() + exp_beat.size() + exp_done.size()), 128'(0));

    // Reset in the middle of a data burst.
    push_ar(32'h6000, 8'd15); push_beats(3, 32'h6000, 16);
    request(3, 32'h6000, 32'd16);
    wait_grant_drop(3);
    begin
      int n = 0;
      while (!dvalid[3] && n < 100) begin @(negedge clk); n++; end
      chk("mid_data_reached", 128'(dvalid[3]), 128'(1));
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_status", 128'({busy, error, etype, grant, done}), 128'(0));
    chk("rst_mid_axi", 128'({axi.arvalid, axi.rready, dvalid}), 128'(0));
    chk("rst_mid_data", 128'(data), 128'(0));
    exp_ar.delete(); exp_beat.delete(); exp_done.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // After reset channel 0 wins over channel 2.
    push_ar(32'h7000, 8'd0); push_beats(0, 32'h7000, 1); exp_done.push_back(4'b0001);
    request(0, 32'h7000, 32'd1);
    request(2, 32'h8000, 32'd1);
    begin
      int n = 0;
      while (done == '0 && n < 200) begin @(negedge clk); n++; end
      req = '0;
      chk("post_reset_done", 128'(done), 128'(4'b0001));
    end
    wait_drain(200, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
